seg_display_ctrl: RTL

//  Sequencer sitting between the calculator datapath and the 4-digit sevenSegments driver.

---
 rtl/seg_display_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// Converts a binary result to four BCD digits with an iterative double-dabble.
// Drives the 4-digit seven-segment driver and shows blinking dashes on error.
module seg_display_ctrl #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999,
  parameter int BLINK_N = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_value,
  input  logic             in_err,
  input  logic             blink_en,
  input  logic             disp_on,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic             display,
  output logic             err,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is taken on a clk edge where in_valid and in_ready
  // are both high; the producer holds in_valid/in_value/in_err until then.

  localparam int SR_W  = BIN_W + 16;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_adj;
  logic [CNT_W-1:0]   iter_q;
  logic               pend_err_q;
  logic [BLINK_N-1:0] blink_q;
  logic               bad_in;

  assign bad_in    = in_err | (in_value > MAX_V);
  assign in_ready  = (state_q == IDLE);
  assign busy      = ~in_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = bad_in ? LOAD : CONVERT;
      CONVERT: if (iter_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      iter_q     <= '0;
      pend_err_q <= 1'b0;
      digit0     <= 4'd0;
      digit1     <= 4'd0;
      digit2     <= 4'd0;
      digit3     <= 4'd0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pend_err_q <= bad_in;
            sr_q       <= {16'b0, in_value};
            iter_q     <= CNT_W'(BIN_W);
          end
        end
        CONVERT: begin
          sr_q   <= {sr_adj[SR_W-2:0], 1'b0};
          iter_q <= iter_q - CNT_W'(1);
        end
        LOAD: begin
          done <= 1'b1;
          if (pend_err_q) begin
            // 4'hA decodes to a dash in the segment driver.
            digit0 <= 4'hA;
            digit1 <= 4'hA;
            digit2 <= 4'hA;
            digit3 <= 4'hA;
            err    <= 1'b1;
          end else begin
            digit0 <= sr_q[BIN_W    +: 4];
            digit1 <= sr_q[BIN_W+4  +: 4];
            digit2 <= sr_q[BIN_W+8  +: 4];
            digit3 <= sr_q[BIN_W+12 +: 4];
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_q + BLINK_N'(1);
  end

  // Top counter bit low means the on phase, so blinking starts visible.
  assign display = disp_on & (~(blink_en & err) | ~blink_q[BLINK_N-1]);

endmodule
